// File: rtl/operand_fetch_sequencer.sv
// Operand fetch sequencer: reads operand and pointer bytes for 6502-style opcodes
// through a two-state (issue/capture) memory port and resolves the effective address.
module operand_fetch_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  opcode,
  input  logic [15:0] pc,
  input  logic [7:0]  reg_x,
  input  logic [7:0]  reg_y,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] effective_addr,
  output logic [7:0]  operand1,
  output logic [7:0]  operand2,
  output logic [2:0]  addr_mode,
  output logic [1:0]  instruction_length,
  output logic        page_crossed,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_OP1, S_OP2, S_PLO, S_PHI, S_CALC, S_DONE
  } state_t;

  typedef enum logic [3:0] {
    K_NONE, K_IMM, K_ZP, K_ZPX, K_ABS, K_ABSX, K_ABSY, K_INDX, K_INDY, K_JIND, K_BR
  } kind_t;

  localparam logic [2:0] M_IMM  = 3'b000;
  localparam logic [2:0] M_ZP   = 3'b001;
  localparam logic [2:0] M_ZPX  = 3'b010;
  localparam logic [2:0] M_ABS  = 3'b011;
  localparam logic [2:0] M_ABSX = 3'b100;
  localparam logic [2:0] M_ABSY = 3'b101;
  localparam logic [2:0] M_INDX = 3'b110;
  localparam logic [2:0] M_INDY = 3'b111;

  function automatic kind_t decode_kind(input logic [7:0] op);
    case (op)
      8'hA9, 8'h69:                     return K_IMM;
      8'hA5, 8'h85, 8'h65:              return K_ZP;
      8'hB5:                            return K_ZPX;
      8'hAD, 8'h8D, 8'h4C:              return K_ABS;
      8'hBD:                            return K_ABSX;
      8'hB9:                            return K_ABSY;
      8'hA1:                            return K_INDX;
      8'hB1:                            return K_INDY;
      8'h6C:                            return K_JIND;
      8'h10, 8'h30, 8'h50, 8'h70,
      8'h90, 8'hB0, 8'hD0, 8'hF0:       return K_BR;
      default:                          return K_NONE;
    endcase
  endfunction

  function automatic logic [1:0] kind_len(input kind_t k);
    case (k)
      K_NONE:                         return 2'd1;
      K_ABS, K_ABSX, K_ABSY, K_JIND:  return 2'd3;
      default:                        return 2'd2;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        cap_q, cap_d;
  kind_t       kind_q, kind_in, kind_c;
  logic [15:0] pc_q, pc_c;
  logic [7:0]  x_q, y_q, op1_q, op2_q, lo_q;

  logic        rd_state;
  logic [15:0] rd_addr;
  logic [7:0]  ptr_x;

  logic [7:0]  op1_v, op2_v, hi_v;
  logic [15:0] base_v, pc2_v;
  logic signed [7:0]  br_disp;
  logic signed [15:0] br_off;

  logic [15:0] ea_c;
  logic [7:0]  o1_c, o2_c;
  logic [2:0]  mode_c;
  logic [1:0]  len_c;
  logic        pcx_c;
  logic        enter_done;

  assign kind_in = decode_kind(opcode);
  assign kind_c  = (state_q == S_IDLE) ? kind_in : kind_q;
  assign pc_c    = (state_q == S_IDLE) ? pc : pc_q;
  assign ptr_x   = op1_q + x_q;

  // Control: state register with cap_q selecting the capture half of each read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cap_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (kind_len(kind_in) == 2'd1) ? S_DONE : S_OP1;
      end
      S_OP1: begin
        if (!cap_q)                                      cap_d   = 1'b1;
        else if (kind_len(kind_q) == 2'd3)               state_d = S_OP2;
        else if (kind_q == K_INDX || kind_q == K_INDY)   state_d = S_PLO;
        else                                             state_d = S_DONE;
      end
      S_OP2: begin
        if (!cap_q)                 cap_d   = 1'b1;
        else if (kind_q == K_JIND)  state_d = S_PLO;
        else                        state_d = S_DONE;
      end
      S_PLO: begin
        if (!cap_q) cap_d   = 1'b1;
        else        state_d = S_PHI;
      end
      S_PHI: begin
        if (!cap_q) cap_d   = 1'b1;
        else        state_d = S_DONE;
      end
      // Address resolution happens on the edge into DONE; CALC is never dwelt in.
      S_CALC:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_state = 1'b0;
    rd_addr  = 16'h0000;
    case (state_q)
      S_OP1: begin rd_state = 1'b1; rd_addr = pc_q + 16'd1; end
      S_OP2: begin rd_state = 1'b1; rd_addr = pc_q + 16'd2; end
      S_PLO: begin
        rd_state = 1'b1;
        case (kind_q)
          K_INDX:  rd_addr = {8'h00, ptr_x};
          K_INDY:  rd_addr = {8'h00, op1_q};
          default: rd_addr = {op2_q, op1_q};
        endcase
      end
      // High pointer byte wraps within its page (zero page, or op2 page for JMP indirect)
      S_PHI: begin
        rd_state = 1'b1;
        case (kind_q)
          K_INDX:  rd_addr = {8'h00, ptr_x + 8'd1};
          K_INDY:  rd_addr = {8'h00, op1_q + 8'd1};
          default: rd_addr = {op2_q, op1_q + 8'd1};
        endcase
      end
      default: ;
    endcase
  end

  assign mem_rd   = rd_state & ~cap_q;
  assign mem_addr = mem_rd ? rd_addr : 16'h0000;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

  // Working data: latched on accept and on each capture half
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start) begin
      kind_q <= kind_in;
      pc_q   <= pc;
      x_q    <= reg_x;
      y_q    <= reg_y;
    end
    if (cap_q) begin
      case (state_q)
        S_OP1:   op1_q <= mem_rdata;
        S_OP2:   op2_q <= mem_rdata;
        S_PLO:   lo_q  <= mem_rdata;
        default: ;
      endcase
    end
  end

  // The byte arriving in the final capture cycle is bypassed straight from mem_rdata
  assign op1_v   = (state_q == S_OP1) ? mem_rdata : op1_q;
  assign op2_v   = (state_q == S_OP2) ? mem_rdata : op2_q;
  assign hi_v    = mem_rdata;
  assign pc2_v   = pc_c + 16'd2;
  assign br_disp = op1_v;
  assign br_off  = 16'(br_disp);

  always_comb begin
    ea_c   = pc_c;
    o1_c   = op1_v;
    o2_c   = 8'h00;
    mode_c = M_IMM;
    len_c  = kind_len(kind_c);
    pcx_c  = 1'b0;
    base_v = {op2_v, op1_v};
    case (kind_c)
      K_IMM: ea_c = pc_c + 16'd1;
      K_ZP: begin
        ea_c   = {8'h00, op1_v};
        mode_c = M_ZP;
      end
      K_ZPX: begin
        ea_c   = {8'h00, op1_v + x_q};
        mode_c = M_ZPX;
      end
      K_ABS: begin
        ea_c   = base_v;
        o2_c   = op2_v;
        mode_c = M_ABS;
      end
      K_ABSX: begin
        ea_c   = base_v + {8'h00, x_q};
        o2_c   = op2_v;
        mode_c = M_ABSX;
        pcx_c  = (base_v[15:8] != ea_c[15:8]);
      end
      K_ABSY: begin
        ea_c   = base_v + {8'h00, y_q};
        o2_c   = op2_v;
        mode_c = M_ABSY;
        pcx_c  = (base_v[15:8] != ea_c[15:8]);
      end
      K_INDX: begin
        ea_c   = {hi_v, lo_q};
        mode_c = M_INDX;
      end
      K_INDY: begin
        base_v = {hi_v, lo_q};
        ea_c   = base_v + {8'h00, y_q};
        mode_c = M_INDY;
        pcx_c  = (base_v[15:8] != ea_c[15:8]);
      end
      K_JIND: begin
        ea_c   = {hi_v, lo_q};
        o2_c   = op2_v;
        mode_c = M_ABS;
      end
      K_BR: begin
        ea_c  = pc2_v + $unsigned(br_off);
        pcx_c = (pc2_v[15:8] != ea_c[15:8]);
      end
      default: o1_c = 8'h00;
    endcase
  end

  assign enter_done = (state_d == S_DONE) && (state_q != S_DONE);

  // Result registers: loaded on the edge into DONE, held until the next result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      effective_addr     <= 16'h0000;
      operand1           <= 8'h00;
      operand2           <= 8'h00;
      addr_mode          <= M_IMM;
      instruction_length <= 2'd1;
      page_crossed       <= 1'b0;
    end else if (enter_done) begin
      effective_addr     <= ea_c;
      operand1           <= o1_c;
      operand2           <= o2_c;
      addr_mode          <= mode_c;
      instruction_length <= len_c;
      page_crossed       <= pcx_c;
    end
  end

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Scoreboard bench for operand_fetch_sequencer: directed opcodes against a byte memory model,
// checking read addresses, results, done latency, result hold and reset behaviour.
module tb_operand_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  opcode = 8'h00;
  logic [15:0] pc = 16'h0000;
  logic [7:0]  reg_x = 8'h00;
  logic [7:0]  reg_y = 8'h00;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic [15:0] effective_addr;
  logic [7:0]  operand1, operand2;
  logic [2:0]  addr_mode;
  logic [1:0]  instruction_length;
  logic        page_crossed, busy, done;

  operand_fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .pc(pc),
    .reg_x(reg_x), .reg_y(reg_y), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .effective_addr(effective_addr), .operand1(operand1),
    .operand2(operand2), .addr_mode(addr_mode), .instruction_length(instruction_length),
    .page_crossed(page_crossed), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ea;
    logic [7:0]  o1;
    logic [7:0]  o2;
    logic [2:0]  mode;
    logic [1:0]  len;
    logic        pcx;
    int          lat;
    int          t;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] rdq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  mem_q = 8'h00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd) mem_q <= mem[mem_addr];
  end
  assign mem_rdata = mem_q;

  function automatic void chk(input string nm, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void flag_fail(input string nm, input int unsigned act);
    total++;
    bad++;
    $display("FAIL %s actual=%0h expected=none (t=%0t)", nm, act, $time);
  endfunction

  // Monitor: read addresses, idle address, done results/latency, and one-cycle hold
  exp_t hold_e;
  logic hold_pend = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (!mem_rd) chk("mem_addr_idle", mem_addr, 0);
      else if (rdq.size() == 0) flag_fail("unexpected_read", mem_addr);
      else chk("read_addr", mem_addr, rdq.pop_front());
      if (hold_pend) begin
        chk("hold_ea", effective_addr, hold_e.ea);
        chk("hold_op1", operand1, hold_e.o1);
        hold_pend = 1'b0;
      end
      if (done) begin
        if (sb.size() == 0) flag_fail("unexpected_done", effective_addr);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("ea", effective_addr, e.ea);
          chk("operand1", operand1, e.o1);
          chk("operand2", operand2, e.o2);
          chk("addr_mode", addr_mode, e.mode);
          chk("length", instruction_length, e.len);
          chk("page_crossed", page_crossed, e.pcx);
          chk("latency", cyc - e.t, e.lat);
          chk("busy_at_done", busy, 1);
          hold_e    = e;
          hold_pend = 1'b1;
        end
      end
    end
  end

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) flag_fail("idle_timeout", g);
  endtask

  task automatic issue(input logic [7:0] op, input logic [15:0] p, input logic [7:0] x,
                       input logic [7:0] y, input logic [15:0] ea, input logic [7:0] o1,
                       input logic [7:0] o2, input logic [2:0] mode, input logic [1:0] len,
                       input logic pcx, input int n, input logic [15:0] r0,
                       input logic [15:0] r1, input logic [15:0] r2, input logic [15:0] r3);
    exp_t e;
    logic [15:0] rr [4];
    wait_idle();
    rr[0] = r0; rr[1] = r1; rr[2] = r2; rr[3] = r3;
    for (int i = 0; i < n; i++) rdq.push_back(rr[i]);
    e.ea = ea; e.o1 = o1; e.o2 = o2; e.mode = mode; e.len = len; e.pcx = pcx;
    e.lat = 1 + 2 * n; e.t = cyc;
    sb.push_back(e);
    opcode = op; pc = p; reg_x = x; reg_y = y; start = 1'b1;
    @(negedge clk);
    // A start while busy, with altered inputs, must be ignored
    opcode = 8'hA9; pc = 16'hFFF0; reg_x = 8'h77; reg_y = 8'h99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0201] = 8'h42;
    mem[16'h0301] = 8'h10;
    mem[16'h0401] = 8'hF0;
    mem[16'h0501] = 8'h34; mem[16'h0502] = 8'h12;
    mem[16'h0601] = 8'hF0; mem[16'h0602] = 8'h12;
    mem[16'h0701] = 8'h00; mem[16'h0702] = 8'h20;
    mem[16'h0021] = 8'h20; mem[16'h0024] = 8'h00; mem[16'h0025] = 8'h30;
    mem[16'h0901] = 8'h80; mem[16'h0080] = 8'hF0; mem[16'h0081] = 8'h12;
    mem[16'h0A01] = 8'hFF; mem[16'h0A02] = 8'h02;
    mem[16'h02FF] = 8'h34; mem[16'h0200] = 8'h12;
    mem[16'h10FE] = 8'h02;
    mem[16'h1001] = 8'hFE;
    mem[16'h0B01] = 8'hFE; mem[16'h00FF] = 8'h78; mem[16'h0000] = 8'h56;
    mem[16'h0D01] = 8'h20;
    mem[16'h0C01] = 8'hCD; mem[16'h0C02] = 8'hAB;

    #23;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ea", effective_addr, 0);
    chk("rst_op1", operand1, 0);
    chk("rst_op2", operand2, 0);
    chk("rst_mode", addr_mode, 0);
    chk("rst_len", instruction_length, 1);
    chk("rst_pcx", page_crossed, 0);
    @(negedge clk);
    rst = 1'b0;

    //     op     pc        x      y      ea        o1     o2     mode  len  pcx n  reads
    issue(8'hEA, 16'h4000, 8'h00, 8'h00, 16'h4000, 8'h00, 8'h00, 3'd0, 2'd1, 0, 0, 0, 0, 0, 0);
    issue(8'hA9, 16'h0200, 8'h00, 8'h00, 16'h0201, 8'h42, 8'h00, 3'd0, 2'd2, 0, 1, 16'h0201, 0, 0, 0);
    issue(8'hA5, 16'h0300, 8'h00, 8'h00, 16'h0010, 8'h10, 8'h00, 3'd1, 2'd2, 0, 1, 16'h0301, 0, 0, 0);
    issue(8'hB5, 16'h0400, 8'h20, 8'h00, 16'h0010, 8'hF0, 8'h00, 3'd2, 2'd2, 0, 1, 16'h0401, 0, 0, 0);
    issue(8'hAD, 16'h0500, 8'h00, 8'h00, 16'h1234, 8'h34, 8'h12, 3'd3, 2'd3, 0, 2, 16'h0501, 16'h0502, 0, 0);
    issue(8'hBD, 16'h0600, 8'h20, 8'h00, 16'h1310, 8'hF0, 8'h12, 3'd4, 2'd3, 1, 2, 16'h0601, 16'h0602, 0, 0);
    issue(8'hB9, 16'h0700, 8'h00, 8'h05, 16'h2005, 8'h00, 8'h20, 3'd5, 2'd3, 0, 2, 16'h0701, 16'h0702, 0, 0);
    issue(8'hA1, 16'h0020, 8'h04, 8'h00, 16'h3000, 8'h20, 8'h00, 3'd6, 2'd2, 0, 3, 16'h0021, 16'h0024, 16'h0025, 0);
    issue(8'hB1, 16'h0900, 8'h00, 8'h20, 16'h1310, 8'h80, 8'h00, 3'd7, 2'd2, 1, 3, 16'h0901, 16'h0080, 16'h0081, 0);
    issue(8'h6C, 16'h0A00, 8'h00, 8'h00, 16'h1234, 8'hFF, 8'h02, 3'd3, 2'd3, 0, 4, 16'h0A01, 16'h0A02, 16'h02FF, 16'h0200);
    issue(8'hD0, 16'h10FD, 8'h00, 8'h00, 16'h1101, 8'h02, 8'h00, 3'd0, 2'd2, 1, 1, 16'h10FE, 0, 0, 0);
    issue(8'hF0, 16'h1000, 8'h00, 8'h00, 16'h1000, 8'hFE, 8'h00, 3'd0, 2'd2, 0, 1, 16'h1001, 0, 0, 0);
    issue(8'hA1, 16'h0B00, 8'h01, 8'h00, 16'h5678, 8'hFE, 8'h00, 3'd6, 2'd2, 0, 3, 16'h0B01, 16'h00FF, 16'h0000, 0);

    // Reset asserted while the A1 low-pointer read is on the bus
    wait_idle();
    rdq.push_back(16'h0D01);
    rdq.push_back(16'h0024);
    opcode = 8'hA1; pc = 16'h0D00; reg_x = 8'h04; reg_y = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("plo_mem_rd", mem_rd, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_mem_rd", mem_rd, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ea", effective_addr, 0);
    chk("midrst_len", instruction_length, 1);
    @(negedge clk);
    rst = 1'b0;
    issue(8'hAD, 16'h0C00, 8'h00, 8'h00, 16'hABCD, 8'hCD, 8'hAB, 3'd3, 2'd3, 0, 2, 16'h0C01, 16'h0C02, 0, 0);

    begin
      int g = 0;
      while (sb.size() != 0 && g < 100) begin
        @(negedge clk);
        g++;
      end
    end
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("reads_drained", rdq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
